mips_alu: RTL and testbench
===========================

// Module: mips_alu
// PURPOSE
//  32-bit MIPS execute-stage ALU. Decodes the primary opcode (alu_op) and, for R-type, the funct field.
//  Produces a registered result, a zero flag and a register-file write-enable for the writeback stage.
// PARAMETERS
//  none (width fixed at 32; encodings are localparams in mips_alu_pkg)
// PORTS
//  clk       in   1   clock; all outputs update on rising edge
//  rst_n     in   1   reset, asynchronous, active-low
//  input1    in   32  operand A (rs); shift amount taken from input1[4:0]
//  input2    in   32  operand B (rt, or immediate already extended by decode)
//  alu_op    in   6   MIPS primary opcode
//  func      in   6   R-type funct field; ignored when alu_op!=6'b000000
//  result    out  32  registered ALU result
//  zero      out  1   registered, 1 when next result==0
//  wr_file   out  1   registered register-file write enable
// BEHAVIOUR
//  - Reset (rst_n=0, async): result=0, zero=0, wr_file=0; held until rst_n=1; mid-op reset discards the op.
//  - Latency 1 cycle: inputs sampled at posedge, outputs valid after it; no handshake, new op every cycle.
//  - R-type (alu_op=000000), wr_file=1 for listed funct:
//    100000 add, 100001 addu, 100010 sub, 100011 subu (A-B), 100100 and, 100101 or, 100110 xor,
//    100111 nor, 101010 slt (signed, result 0/1), 101011 sltu;
//    000000 sll, 000010 srl, 000011 sra: B shifted by A[4:0];
//    000100 sllv, 000110 srlv, 000111 srav: B shifted by A[4:0].
//    Unlisted funct -> result=0, wr_file=0.
//  - I-type: 001000/001001 addi(u) A+B; 001100 andi; 001101 ori; 001110 xori; 001010 slti; 001011 sltiu;
//    001111 lui {B[15:0],16'h0}; all wr_file=1.
//  - Loads 100000 lb, 100001 lh, 100011 lw, 100100 lbu, 100101 lhu: result=A+B (address), wr_file=1.
//  - Stores 101000 sb, 101001 sh, 101011 sw: result=A+B, wr_file=0.
//  - Opcode 101010: signed set-less-than A<B, result 0/1, wr_file=0.
//  - Branches 000100 beq, 000101 bne: result=A-B, wr_file=0; zero used for the branch decision.
//  - Any other opcode: result=0, wr_file=0, zero=1.
//  - Arithmetic is modulo 2^32; wrap-around silent unless overflow detection is compiled in.
//  - zero is computed from the same next-result value, never from the stale register.
//  - sra/srav replicate B[31]; shift by 0 returns B unchanged; shift by 31 allowed.
// CONFIGURATION
//  MIPS_ALU_OVERFLOW_EN: adds output port ovf (1 bit, reset 0, registered).
//    With macro: for add, sub and addi, ovf=1 on signed overflow; wr_file forced 0 that cycle; result still the wrapped sum.
//    Without macro: no ovf port; add/sub/addi behave like addu/subu/addiu.
// STRUCTURE
//  mips_alu_pkg: opcode/funct localparams (OP_RTYPE, OP_LW, FN_ADD, ...) and an ALU-operation enum.
//  Sub-module mips_alu_shifter: combinational barrel shifter (value, shamt[4:0], dir, arith) -> 32-bit.
//  Top: combinational decode/compute, one output register stage.
// TESTING
//  1. R add: A=100, B=99, op=000000, fn=100000 -> next cycle result=199, zero=0, wr_file=1.
//  2. R sub: A=99, B=99, fn=100010 -> result=0, zero=1, wr_file=1.
//  3. R and/or: A=100, B=99; fn=100100 -> 96; fn=100101 -> 103; wr_file=1.
//  4. lb op=100000 and lw op=100011, A=100, B=99 -> result=199, wr_file=1; sw op=101011 -> result=199, wr_file=0.
//  5. op=101010, A=100, B=99 -> result=0, zero=1, wr_file=0; A=-1, B=1 -> result=1.
//  6. Assert rst_n=0 mid-stream between edges -> outputs 0 immediately; sra A=4, B=32'h8000_0000 -> 32'hF800_0000.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// mips_alu shared encodings and ALU operation enum.
// MIPS_ALU_OVERFLOW_EN enables signed-overflow detection on add/sub/addi.
package mips_alu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SLT   = 6'b101010;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

`ifdef MIPS_ALU_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    ALU_ZERO,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_LUI
  } alu_fn_e;

endpackage

// File: rtl/mips_alu_shifter.sv
// mips_alu combinational barrel shifter.
// dir=0 shifts left, dir=1 right; arith replicates value[31].
module mips_alu_shifter (
  input  logic [31:0] value,
  input  logic [4:0]  shamt,
  input  logic        dir,
  input  logic        arith,
  output logic [31:0] res
);

  logic fill;
  logic [31:0] st [0:5];

  assign fill  = arith & value[31];
  assign st[0] = value;

  for (genvar i = 0; i < 5; i++) begin : g_stage
    localparam int S = 1 << i;
    always_comb begin
      st[i+1] = st[i];
      if (shamt[i]) begin
        if (dir) st[i+1] = {{S{fill}}, st[i][31:S]};
        else     st[i+1] = {st[i][31-S:0], {S{1'b0}}};
      end
    end
  end

  assign res = st[5];

endmodule

// File: rtl/mips_alu.sv
// mips_alu: 32-bit MIPS execute ALU with one registered output stage.
// MIPS_ALU_OVERFLOW_EN adds the ovf output and overflow write suppression.
module mips_alu
  import mips_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] input1,
  input  logic [31:0] input2,
  input  logic [5:0]  alu_op,
  input  logic [5:0]  func,
  output logic [31:0] result,
  output logic        zero,
  output logic        wr_file
`ifdef MIPS_ALU_OVERFLOW_EN
  ,
  output logic        ovf
`endif
);

  alu_fn_e     fn_sel;
  logic        wr_nxt;
  logic        chk_add;
  logic        chk_sub;
  logic        ovf_nxt;
  logic        wr_eff;
  logic        sh_dir;
  logic        sh_arith;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] sh_out;
  logic [31:0] res_nxt;

  assign sum  = input1 + input2;
  assign diff = input1 - input2;

  always_comb begin
    fn_sel  = ALU_ZERO;
    wr_nxt  = 1'b0;
    chk_add = 1'b0;
    chk_sub = 1'b0;
    case (alu_op)
      OP_RTYPE: begin
        wr_nxt = 1'b1;
        case (func)
          FN_ADD:  begin fn_sel = ALU_ADD; chk_add = 1'b1; end
          FN_ADDU: fn_sel = ALU_ADD;
          FN_SUB:  begin fn_sel = ALU_SUB; chk_sub = 1'b1; end
          FN_SUBU: fn_sel = ALU_SUB;
          FN_AND:  fn_sel = ALU_AND;
          FN_OR:   fn_sel = ALU_OR;
          FN_XOR:  fn_sel = ALU_XOR;
          FN_NOR:  fn_sel = ALU_NOR;
          FN_SLT:  fn_sel = ALU_SLT;
          FN_SLTU: fn_sel = ALU_SLTU;
          FN_SLL,
          FN_SLLV: fn_sel = ALU_SLL;
          FN_SRL,
          FN_SRLV: fn_sel = ALU_SRL;
          FN_SRA,
          FN_SRAV: fn_sel = ALU_SRA;
          default: wr_nxt = 1'b0;
        endcase
      end
      OP_ADDI:  begin fn_sel = ALU_ADD; wr_nxt = 1'b1; chk_add = 1'b1; end
      OP_ADDIU: begin fn_sel = ALU_ADD;  wr_nxt = 1'b1; end
      OP_ANDI:  begin fn_sel = ALU_AND;  wr_nxt = 1'b1; end
      OP_ORI:   begin fn_sel = ALU_OR;   wr_nxt = 1'b1; end
      OP_XORI:  begin fn_sel = ALU_XOR;  wr_nxt = 1'b1; end
      OP_SLTI:  begin fn_sel = ALU_SLT;  wr_nxt = 1'b1; end
      OP_SLTIU: begin fn_sel = ALU_SLTU; wr_nxt = 1'b1; end
      OP_LUI:   begin fn_sel = ALU_LUI;  wr_nxt = 1'b1; end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        fn_sel = ALU_ADD;
        wr_nxt = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: fn_sel = ALU_ADD;
      OP_SLT:              fn_sel = ALU_SLT;
      OP_BEQ, OP_BNE:      fn_sel = ALU_SUB;
      default:             fn_sel = ALU_ZERO;
    endcase
  end

  assign sh_dir   = (fn_sel != ALU_SLL);
  assign sh_arith = (fn_sel == ALU_SRA);

  mips_alu_shifter u_shifter (
    .value (input2),
    .shamt (input1[4:0]),
    .dir   (sh_dir),
    .arith (sh_arith),
    .res   (sh_out)
  );

  always_comb begin
    res_nxt = '0;
    case (fn_sel)
      ALU_ADD:  res_nxt = sum;
      ALU_SUB:  res_nxt = diff;
      ALU_AND:  res_nxt = input1 & input2;
      ALU_OR:   res_nxt = input1 | input2;
      ALU_XOR:  res_nxt = input1 ^ input2;
      ALU_NOR:  res_nxt = ~(input1 | input2);
      ALU_SLT:  res_nxt = {31'b0, $signed(input1) < $signed(input2)};
      ALU_SLTU: res_nxt = {31'b0, input1 < input2};
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  res_nxt = sh_out;
      ALU_LUI:  res_nxt = {input2[15:0], 16'h0000};
      default:  res_nxt = '0;
    endcase
  end

  // Signed overflow: operands agree (add) or differ (sub) in sign and result flips.
  assign ovf_nxt = (chk_add & (input1[31] == input2[31]) & (sum[31] != input1[31]))
                 | (chk_sub & (input1[31] != input2[31]) & (diff[31] != input1[31]));
  assign wr_eff  = wr_nxt & ~(OVF_EN & ovf_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= '0;
      zero    <= 1'b0;
      wr_file <= 1'b0;
    end else begin
      result  <= res_nxt;
      zero    <= (res_nxt == 32'h0);
      wr_file <= wr_eff;
    end
  end

`ifdef MIPS_ALU_OVERFLOW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= 1'b0;
    else        ovf <= ovf_nxt;
  end
`endif

endmodule

// File: tb/tb_mips_alu.sv
// Directed self-checking bench for mips_alu.
// Build with MIPS_ALU_OVERFLOW_EN to also exercise ovf.
module tb_mips_alu;

`ifdef MIPS_ALU_OVERFLOW_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] input1;
  logic [31:0] input2;
  logic [5:0]  alu_op;
  logic [5:0]  func;
  logic [31:0] result;
  logic        zero;
  logic        wr_file;
`ifdef MIPS_ALU_OVERFLOW_EN
  logic        ovf;
`endif

  int total = 0;
  int bad   = 0;

  mips_alu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .input1  (input1),
    .input2  (input2),
    .alu_op  (alu_op),
    .func    (func),
    .result  (result),
    .zero    (zero),
    .wr_file (wr_file)
`ifdef MIPS_ALU_OVERFLOW_EN
    ,
    .ovf     (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive at negedge, sample 1ns after the capturing posedge.
  task automatic run(input string tag, input logic [5:0] op,
                     input logic [5:0] fn, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_r,
                     input logic exp_w, input logic exp_o = 1'b0);
    alu_op = op;
    func   = fn;
    input1 = a;
    input2 = b;
    @(posedge clk);
    #1;
    chk({tag, ".res"}, result, exp_r);
    chk({tag, ".zero"}, {31'b0, zero}, {31'b0, exp_r == 32'h0});
    chk({tag, ".wr"}, {31'b0, wr_file}, {31'b0, exp_w});
`ifdef MIPS_ALU_OVERFLOW_EN
    chk({tag, ".ovf"}, {31'b0, ovf}, {31'b0, exp_o});
`else
    if (exp_o) chk({tag, ".wrap"}, result, exp_r);
`endif
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    input1 = 32'd100;
    input2 = 32'd99;
    alu_op = 6'b000000;
    func   = 6'b100000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.res", result, 32'h0);
    chk("rst.zero", {31'b0, zero}, 32'h0);
    chk("rst.wr", {31'b0, wr_file}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run("add",  6'b000000, 6'b100000, 32'd100, 32'd99, 32'd199, 1'b1);
    run("sub",  6'b000000, 6'b100010, 32'd99,  32'd99, 32'd0,   1'b1);
    run("and",  6'b000000, 6'b100100, 32'd100, 32'd99, 32'd96,  1'b1);
    run("or",   6'b000000, 6'b100101, 32'd100, 32'd99, 32'd103, 1'b1);
    run("xor",  6'b000000, 6'b100110, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b1);
    run("nor",  6'b000000, 6'b100111, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1);
    run("slt",  6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1);
    run("sltu", 6'b000000, 6'b101011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    run("addu", 6'b000000, 6'b100001, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    run("subu", 6'b000000, 6'b100011, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1);
    run("sll",  6'b000000, 6'b000000, 32'd4, 32'd1, 32'd16, 1'b1);
    run("sllhi",6'b000000, 6'b000000, 32'h25, 32'd1, 32'd32, 1'b1);
    run("srl",  6'b000000, 6'b000010, 32'd4, 32'h8000_0000, 32'h0800_0000, 1'b1);
    run("sra",  6'b000000, 6'b000011, 32'd4, 32'h8000_0000, 32'hF800_0000, 1'b1);
    run("sra31",6'b000000, 6'b000011, 32'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run("srav0",6'b000000, 6'b000111, 32'd0, 32'h8000_0001, 32'h8000_0001, 1'b1);
    run("sllv", 6'b000000, 6'b000100, 32'd31, 32'd1, 32'h8000_0000, 1'b1);
    run("srlv", 6'b000000, 6'b000110, 32'd8, 32'hABCD_0000, 32'h00AB_CD00, 1'b1);
    run("badfn",6'b000000, 6'b111111, 32'd7, 32'd9, 32'd0, 1'b0);
    run("addi", 6'b001000, 6'b000000, 32'd10, 32'hFFFF_FFFD, 32'd7, 1'b1);
    run("andi", 6'b001100, 6'b000000, 32'hFFFF_00FF, 32'h0000_0F0F, 32'h0000_000F, 1'b1);
    run("ori",  6'b001101, 6'b000000, 32'h1200_0000, 32'h0000_0034, 32'h1200_0034, 1'b1);
    run("xori", 6'b001110, 6'b000000, 32'hFF, 32'h0F, 32'hF0, 1'b1);
    run("slti", 6'b001010, 6'b000000, 32'hFFFF_FFFB, 32'd3, 32'd1, 1'b1);
    run("sltiu",6'b001011, 6'b000000, 32'd3, 32'hFFFF_FFFB, 32'd1, 1'b1);
    run("lui",  6'b001111, 6'b000000, 32'd5, 32'hABCD_1234, 32'h1234_0000, 1'b1);
    run("lb",   6'b100000, 6'b101010, 32'd100, 32'd99, 32'd199, 1'b1);
    run("lw",   6'b100011, 6'b000000, 32'd100, 32'd99, 32'd199, 1'b1);
    run("lhu",  6'b100101, 6'b000000, 32'h1000, 32'h10, 32'h1010, 1'b1);
    run("sw",   6'b101011, 6'b000000, 32'd100, 32'd99, 32'd199, 1'b0);
    run("sb",   6'b101000, 6'b000000, 32'd1, 32'd2, 32'd3, 1'b0);
    run("slt_i",6'b101010, 6'b000000, 32'd100, 32'd99, 32'd0, 1'b0);
    run("slt_n",6'b101010, 6'b000000, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    run("beq",  6'b000100, 6'b000000, 32'd5, 32'd5, 32'd0, 1'b0);
    run("bne",  6'b000101, 6'b000000, 32'd5, 32'd3, 32'd2, 1'b0);
    run("badop",6'b111111, 6'b100000, 32'd5, 32'd3, 32'd0, 1'b0);

    run("addov", 6'b000000, 6'b100000, 32'h7FFF_FFFF, 32'd1,
        32'h8000_0000, !OVF, 1'b1);
    run("subov", 6'b000000, 6'b100010, 32'h8000_0000, 32'd1,
        32'h7FFF_FFFF, !OVF, 1'b1);
    run("addiov",6'b001000, 6'b000000, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h7FFF_FFFF, !OVF, 1'b1);
    run("adduov",6'b000000, 6'b100001, 32'h7FFF_FFFF, 32'd1,
        32'h8000_0000, 1'b1);

    run("pre", 6'b000000, 6'b100000, 32'd1, 32'd2, 32'd3, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.res", result, 32'h0);
    chk("arst.zero", {31'b0, zero}, 32'h0);
    chk("arst.wr", {31'b0, wr_file}, 32'h0);
    @(posedge clk);
    #1;
    chk("hold.res", result, 32'h0);
    chk("hold.wr", {31'b0, wr_file}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run("post", 6'b000000, 6'b000011, 32'd4, 32'h8000_0000, 32'hF800_0000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
